// File: rtl/wb_write_arbiter.sv
// Writeback arbiter in front of the register file write port: buffers ALU results
// in a small FIFO, gives loads priority, bounds ALU starvation, drops x0 writes.
module wb_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [ADDR_WIDTH-1:0]      alu_rd,
  input  logic [DATA_WIDTH-1:0]      alu_data,
  input  logic                       mem_valid,
  output logic                       mem_ready,
  input  logic [ADDR_WIDTH-1:0]      mem_rd,
  input  logic [DATA_WIDTH-1:0]      mem_data,
  output logic                       wr_en,
  output logic [ADDR_WIDTH-1:0]      wr_reg,
  output logic [DATA_WIDTH-1:0]      wr_data,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] DEPTH_C      = CNT_W'(DEPTH);
  localparam logic [STV_W-1:0] STARVE_MAX_C = STV_W'(STARVE_MAX);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t                fifo_q [DEPTH];
  entry_t                fifo_d [DEPTH];
  logic [PTR_W-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [STV_W-1:0]      starve_q, starve_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_reg_q, wr_reg_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

  logic   nonempty, force_drain, mem_sel, pop, push;
  entry_t head;

  // Handshake: a source transfers on a posedge where valid & ready are both high.
  // Ready is computed from registered state only, never from that source's valid.
  always_comb begin
    nonempty    = (count_q != '0);
    force_drain = (starve_q == STARVE_MAX_C) && nonempty;
    alu_ready   = !rst && (count_q < DEPTH_C);
    mem_ready   = !rst && !force_drain;
    head        = fifo_q[rptr_q];
    // An x0 load is swallowed without using the port, so the FIFO may drain alongside it.
    mem_sel     = mem_valid && mem_ready && (mem_rd != '0);
    pop         = nonempty && !mem_sel;
    push        = alu_valid && alu_ready && (alu_rd != '0);
  end

  always_comb begin
    fifo_d  = fifo_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) begin
      fifo_d[wptr_q] = '{rd: alu_rd, data: alu_data};
      wptr_d         = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (mem_sel && nonempty) begin
      starve_d = (starve_q == STARVE_MAX_C) ? starve_q : starve_q + 1'b1;
    end else if (pop || !nonempty) begin
      starve_d = '0;
    end
  end

  always_comb begin
    wr_en_d   = mem_sel || pop;
    wr_reg_d  = wr_reg_q;
    wr_data_d = wr_data_q;
    if (mem_sel) begin
      wr_reg_d  = mem_rd;
      wr_data_d = mem_data;
    end else if (pop) begin
      wr_reg_d  = head.rd;
      wr_data_d = head.data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      starve_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      starve_q  <= starve_d;
      wr_en_q   <= wr_en_d;
      wr_reg_q  <= wr_reg_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Storage needs no reset: occupancy and pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  assign wr_en      = wr_en_q;
  assign wr_reg     = wr_reg_q;
  assign wr_data    = wr_data_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: per-cycle vector table plus hand-written
// reset and latency sequences, with an expected-write queue checked every cycle.
module tb_wb_write_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid, mem_valid;
  logic          alu_ready, mem_ready;
  logic [AW-1:0] alu_rd, mem_rd;
  logic [DW-1:0] alu_data, mem_data;
  logic          wr_en;
  logic [AW-1:0] wr_reg;
  logic [DW-1:0] wr_data;
  logic [1:0]    fifo_count;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [AW+DW-1:0] exp_q[$];

  wb_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(2), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data), .fifo_count(fifo_count)
  );

  // Clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic          alu_v;
    logic [AW-1:0] alu_rd;
    logic [DW-1:0] alu_d;
    logic          mem_v;
    logic [AW-1:0] mem_rd;
    logic [DW-1:0] mem_d;
    logic          en;
    logic [AW-1:0] wreg;
    logic [DW-1:0] wdat;
    logic [1:0]    cnt;
    logic          ar;
    logic          mr;
  } vec_t;

  vec_t vecs [25];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                       input logic mv, input logic [AW-1:0] mrd, input logic [DW-1:0] md);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
  endtask

  // Scoreboard: every write the port issues must be the next expected one.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 64'({wr_reg, wr_data}), 64'h0);
      end else begin
        chk("sb_write", 64'({wr_reg, wr_data}), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int lat;

    vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0, 32'h0,   1'b0, 5'd0,  32'h0,        2'd1, 1'b1, 1'b1};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,   1'b1, 5'd5,  32'hDEADBEEF, 2'd0, 1'b1, 1'b1};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,   1'b0, 5'd5,  32'hDEADBEEF, 2'd0, 1'b1, 1'b1};
    vecs[3]  = '{1'b1, 5'd3,  32'h11,       1'b1, 5'd4, 32'h22,  1'b1, 5'd4,  32'h22,       2'd1, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,   1'b1, 5'd3,  32'h11,       2'd0, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,   1'b0, 5'd3,  32'h11,       2'd0, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 5'd0,  32'hAAAA,     1'b1, 5'd0, 32'hBBBB, 1'b0, 5'd3, 32'h11,       2'd0, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,   1'b0, 5'd3,  32'h11,       2'd0, 1'b1, 1'b1};
    vecs[8]  = '{1'b1, 5'd1,  32'hA0,       1'b1, 5'd7, 32'h100, 1'b1, 5'd7,  32'h100,      2'd1, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 5'd2,  32'hA1,       1'b1, 5'd7, 32'h101, 1'b1, 5'd7,  32'h101,      2'd2, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 5'd6,  32'hA2,       1'b1, 5'd7, 32'h102, 1'b1, 5'd7,  32'h102,      2'd2, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 5'd6,  32'hA2,       1'b1, 5'd7, 32'h103, 1'b1, 5'd7,  32'h103,      2'd2, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 5'd6,  32'hA2,       1'b1, 5'd7, 32'h104, 1'b1, 5'd7,  32'h104,      2'd2, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 5'd6,  32'hA2,       1'b1, 5'd7, 32'h105, 1'b1, 5'd1,  32'hA0,       2'd1, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 5'd6,  32'hA2,       1'b1, 5'd7, 32'h105, 1'b1, 5'd7,  32'h105,      2'd2, 1'b1, 1'b1};
    vecs[15] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,   1'b1, 5'd2,  32'hA1,       2'd1, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,   1'b1, 5'd6,  32'hA2,       2'd0, 1'b1, 1'b1};
    vecs[17] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,   1'b0, 5'd6,  32'hA2,       2'd0, 1'b1, 1'b1};
    vecs[18] = '{1'b1, 5'd9,  32'h99,       1'b0, 5'd0, 32'h0,   1'b0, 5'd6,  32'hA2,       2'd1, 1'b1, 1'b1};
    vecs[19] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0, 32'hEE,  1'b1, 5'd9,  32'h99,       2'd0, 1'b1, 1'b1};
    vecs[20] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,   1'b0, 5'd9,  32'h99,       2'd0, 1'b1, 1'b1};
    vecs[21] = '{1'b1, 5'd10, 32'h1010,     1'b0, 5'd0, 32'h0,   1'b0, 5'd9,  32'h99,       2'd1, 1'b1, 1'b1};
    vecs[22] = '{1'b1, 5'd11, 32'h1111,     1'b0, 5'd0, 32'h0,   1'b1, 5'd10, 32'h1010,     2'd1, 1'b1, 1'b1};
    vecs[23] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,   1'b1, 5'd11, 32'h1111,     2'd0, 1'b1, 1'b1};
    vecs[24] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,   1'b0, 5'd11, 32'h1111,     2'd0, 1'b1, 1'b1};

    // Reset held two cycles with requests asserted; nothing may be accepted.
    rst = 1'b1;
    drive(1'b1, 5'd8, 32'h8888, 1'b1, 5'd8, 32'h9999);
    #1;
    chk("rst_alu_ready", 64'(alu_ready), 64'h0);
    chk("rst_mem_ready", 64'(mem_ready), 64'h0);
    cyc();
    cyc();
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    chk("idle_wr_en", 64'(wr_en), 64'h0);
    chk("idle_wr_reg", 64'(wr_reg), 64'h0);
    chk("idle_wr_data", 64'(wr_data), 64'h0);
    chk("idle_count", 64'(fifo_count), 64'h0);
    chk("idle_alu_ready", 64'(alu_ready), 64'h1);
    chk("idle_mem_ready", 64'(mem_ready), 64'h1);

    for (int i = 0; i < 25; i++) begin
      drive(vecs[i].alu_v, vecs[i].alu_rd, vecs[i].alu_d, vecs[i].mem_v, vecs[i].mem_rd, vecs[i].mem_d);
      #1;
      chk($sformatf("v%0d_alu_ready", i), 64'(alu_ready), 64'(vecs[i].ar));
      chk($sformatf("v%0d_mem_ready", i), 64'(mem_ready), 64'(vecs[i].mr));
      if (vecs[i].en) exp_q.push_back({vecs[i].wreg, vecs[i].wdat});
      cyc();
      chk($sformatf("v%0d_wr_en", i), 64'(wr_en), 64'(vecs[i].en));
      chk($sformatf("v%0d_wr_reg", i), 64'(wr_reg), 64'(vecs[i].wreg));
      chk($sformatf("v%0d_wr_data", i), 64'(wr_data), 64'(vecs[i].wdat));
      chk($sformatf("v%0d_count", i), 64'(fifo_count), 64'(vecs[i].cnt));
    end

    // Reset mid-operation with two ALU entries buffered behind loads.
    drive(1'b1, 5'd12, 32'hC0C0, 1'b1, 5'd7, 32'h200);
    exp_q.push_back({5'd7, 32'h200});
    cyc();
    chk("mid_fill1_count", 64'(fifo_count), 64'h1);
    drive(1'b1, 5'd13, 32'hC1C1, 1'b1, 5'd7, 32'h201);
    exp_q.push_back({5'd7, 32'h201});
    cyc();
    chk("mid_fill2_count", 64'(fifo_count), 64'h2);
    rst = 1'b1;
    drive(1'b1, 5'd14, 32'hE0E0, 1'b1, 5'd15, 32'hF0F0);
    #1;
    chk("mid_rst_alu_ready", 64'(alu_ready), 64'h0);
    chk("mid_rst_mem_ready", 64'(mem_ready), 64'h0);
    cyc();
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("mid_rst_count", 64'(fifo_count), 64'h0);
    chk("mid_rst_wr_en", 64'(wr_en), 64'h0);
    chk("mid_rst_wr_reg", 64'(wr_reg), 64'h0);
    chk("mid_rst_wr_data", 64'(wr_data), 64'h0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("post_rst_wr_en", 64'(wr_en), 64'h0);
      chk("post_rst_count", 64'(fifo_count), 64'h0);
    end

    // ALU latency into an empty FIFO, bounded wait.
    drive(1'b1, 5'd5, 32'h5A5A5A5A, 1'b0, 5'd0, 32'h0);
    exp_q.push_back({5'd5, 32'h5A5A5A5A});
    cyc();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    lat = 1;
    for (int i = 0; i < 8 && wr_en !== 1'b1; i++) begin
      cyc();
      lat++;
    end
    if (wr_en !== 1'b1) lat = -1;
    chk("alu_latency", 64'(lat), 64'd2);
    chk("alu_lat_wr_reg", 64'(wr_reg), 64'd5);

    cyc();
    cyc();
    chk("exp_q_drained", 64'(exp_q.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
